// File: rtl/fir_pkg.sv
// Shared types and elaboration helpers for the FIR coefficient path.
package fir_pkg;

  localparam logic [7:0] SYNC_CMD_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } fir_ld_state_t;

  function automatic bit coef_w_ok(input int w);
    return (w == 8) || (w == 16);
  endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Framed byte-stream coefficient writer: commits the tap set on the edge its check byte is accepted.
// One byte per clock; in_ready drops for the single cycle after a commit, otherwise always ready.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int         NTAPS    = 4,
  parameter int         COEF_W   = 8,
  parameter logic [7:0] SYNC_CMD = SYNC_CMD_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  input  logic                      abort,
  output logic [NTAPS*COEF_W-1:0]   coef_o,
  output logic                      coef_update,
  output logic                      busy,
  output logic                      err
);

  localparam int BPC    = COEF_W / 8;
  localparam int NBYTES = NTAPS * BPC;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  generate
    if (!coef_w_ok(COEF_W) || (NTAPS < 1)) begin : g_param_err
      $error("fir_coef_loader: COEF_W must be 8 or 16 and NTAPS >= 1");
    end
  endgenerate

  fir_ld_state_t         state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [7:0]            csum;
  logic [NBYTES*8-1:0]   shadow;
  logic                  accept;

  assign in_ready = ~coef_update;
  assign accept   = in_valid & in_ready & ~abort;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    if (in_data == SYNC_CMD) state_nxt = DATA;
        DATA:    if (idx == LAST_IDX) state_nxt = CHECK;
        CHECK:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shadow bytes land in stream order, which already matches the flat bus layout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      csum        <= '0;
      shadow      <= '0;
      coef_o      <= '0;
      coef_update <= 1'b0;
      err         <= 1'b0;
    end else begin
      coef_update <= 1'b0;
      if (abort) begin
        shadow <= '0;
      end else if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == SYNC_CMD) begin
              idx  <= '0;
              csum <= '0;
              err  <= 1'b0;
            end
          end
          DATA: begin
            shadow[int'(idx)*8 +: 8] <= in_data;
            csum <= csum ^ in_data;
            if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
          end
          CHECK: begin
            if (in_data == csum) begin
              coef_o      <= shadow;
              coef_update <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader (NTAPS=4, COEF_W=8): directed vector table, hand sequences, random frames vs a queue model.
module tb_fir_coef_loader;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        abort;
  logic [31:0] coef_o;
  logic        coef_update;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  fir_coef_loader #(.NTAPS(4), .COEF_W(8), .SYNC_CMD(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .coef_o(coef_o),
    .coef_update(coef_update), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is "header, NB payload bytes, XOR of payload".
  bit          m_inframe;
  logic [7:0]  m_q[$];
  logic [31:0] m_coef;
  bit          m_upd;
  bit          m_err;
  bit          m_rdy;

  task automatic model_reset();
    m_inframe = 0; m_q.delete(); m_coef = '0; m_upd = 0; m_err = 0; m_rdy = 1;
  endtask

  task automatic model_clock(input bit v, input logic [7:0] d, input bit ab);
    bit          upd_n;
    logic [7:0]  x;
    upd_n = 0;
    if (ab) begin
      m_inframe = 0;
      m_q.delete();
    end else if (v && m_rdy) begin
      if (!m_inframe) begin
        if (d == 8'hA5) begin
          m_inframe = 1; m_q.delete(); m_err = 0;
        end
      end else if (m_q.size() < NB) begin
        m_q.push_back(d);
      end else begin
        x = '0;
        foreach (m_q[i]) x ^= m_q[i];
        if (d == x) begin
          for (int i = 0; i < NB; i++) m_coef[i*8 +: 8] = m_q[i];
          upd_n = 1;
        end else begin
          m_err = 1;
        end
        m_inframe = 0;
        m_q.delete();
      end
    end
    m_upd = upd_n;
    m_rdy = !upd_n;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit ab);
    in_valid = v; in_data = d; abort = ab;
    model_clock(v, d, ab);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          ab;
    bit          rdy;
    logic [31:0] coef;
    bit          upd;
    bit          busy;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input logic [7:0] d, input bit ab, input bit rdy,
                     input logic [31:0] coef, input bit upd, input bit bsy, input bit e);
    vec_t r;
    r.v = v; r.d = d; r.ab = ab; r.rdy = rdy; r.coef = coef; r.upd = upd; r.busy = bsy; r.err = e;
    tbl.push_back(r);
  endtask

  localparam logic [31:0] C1 = 32'h04030201;
  localparam logic [31:0] C2 = 32'h40302010;
  localparam logic [31:0] C3 = 32'h030201A5;

  initial begin
    logic [7:0]  src[$];
    logic [7:0]  gen[$];
    logic [7:0]  b, cs;
    int          low_cnt, pulses;
    bit          v, ab, acc;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
    model_reset();
    #12;
    chk("reset_coef", coef_o, 32'h0);
    chk("reset_upd", 32'(coef_update), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_rdy", 32'(in_ready), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // good frame
    add(1, 8'hA5, 0, 1, 0, 0, 1, 0);
    add(1, 8'h01, 0, 1, 0, 0, 1, 0);
    add(1, 8'h02, 0, 1, 0, 0, 1, 0);
    add(1, 8'h03, 0, 1, 0, 0, 1, 0);
    add(1, 8'h04, 0, 1, 0, 0, 1, 0);
    add(1, 8'h04, 0, 1, C1, 1, 0, 0);
    add(0, 8'h00, 0, 0, C1, 0, 0, 0);
    // bad check byte
    add(1, 8'hA5, 0, 1, C1, 0, 1, 0);
    add(1, 8'h11, 0, 1, C1, 0, 1, 0);
    add(1, 8'h22, 0, 1, C1, 0, 1, 0);
    add(1, 8'h33, 0, 1, C1, 0, 1, 0);
    add(1, 8'h44, 0, 1, C1, 0, 1, 0);
    add(1, 8'h00, 0, 1, C1, 0, 0, 1);
    // preamble noise, then the good frame; err clears on the header
    add(1, 8'h00, 0, 1, C1, 0, 0, 1);
    add(1, 8'hFF, 0, 1, C1, 0, 0, 1);
    add(1, 8'h5A, 0, 1, C1, 0, 0, 1);
    add(1, 8'hA5, 0, 1, C1, 0, 1, 0);
    add(1, 8'h01, 0, 1, C1, 0, 1, 0);
    add(1, 8'h02, 0, 1, C1, 0, 1, 0);
    add(1, 8'h03, 0, 1, C1, 0, 1, 0);
    add(1, 8'h04, 0, 1, C1, 0, 1, 0);
    add(1, 8'h04, 0, 1, C1, 1, 0, 0);
    add(0, 8'h00, 0, 0, C1, 0, 0, 0);
    // abort with a valid byte present
    add(1, 8'hA5, 0, 1, C1, 0, 1, 0);
    add(1, 8'h01, 0, 1, C1, 0, 1, 0);
    add(1, 8'h02, 0, 1, C1, 0, 1, 0);
    add(1, 8'h03, 1, 1, C1, 0, 0, 0);
    add(1, 8'hA5, 0, 1, C1, 0, 1, 0);
    add(1, 8'h10, 0, 1, C1, 0, 1, 0);
    add(1, 8'h20, 0, 1, C1, 0, 1, 0);
    add(1, 8'h30, 0, 1, C1, 0, 1, 0);
    add(1, 8'h40, 0, 1, C1, 0, 1, 0);
    add(1, 8'h40, 0, 1, C2, 1, 0, 0);
    add(0, 8'h00, 0, 0, C2, 0, 0, 0);
    // header value inside the payload is data
    add(1, 8'hA5, 0, 1, C2, 0, 1, 0);
    add(1, 8'hA5, 0, 1, C2, 0, 1, 0);
    add(1, 8'h01, 0, 1, C2, 0, 1, 0);
    add(1, 8'h02, 0, 1, C2, 0, 1, 0);
    add(1, 8'h03, 0, 1, C2, 0, 1, 0);
    add(1, 8'hA5, 0, 1, C3, 1, 0, 0);
    // byte offered during the hold-off is not taken
    add(1, 8'hA5, 0, 0, C3, 0, 0, 0);
    add(0, 8'h00, 0, 1, C3, 0, 0, 0);

    foreach (tbl[i]) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; abort = tbl[i].ab;
      #1;
      chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
      step(tbl[i].v, tbl[i].d, tbl[i].ab);
      chk($sformatf("tbl%0d_coef", i), coef_o, tbl[i].coef);
      chk($sformatf("tbl%0d_upd", i), 32'(coef_update), 32'(tbl[i].upd));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
    end

    // back-to-back frames with in_valid held high
    src = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0C};
    low_cnt = 0; pulses = 0;
    for (int c = 0; c < 40 && src.size() > 0; c++) begin
      in_valid = 1'b1; in_data = src[0]; abort = 1'b0;
      #1;
      acc = in_ready;
      if (!in_ready) low_cnt++;
      step(1'b1, src[0], 1'b0);
      if (acc) void'(src.pop_front());
      if (coef_update) pulses++;
    end
    chk("b2b_drained", 32'(src.size()), 32'd0);
    in_valid = 1'b1; in_data = 8'h00; #1;
    chk("b2b_holdoff_after_last", 32'(in_ready), 32'h0);
    step(1'b1, 8'h00, 1'b0);
    chk("b2b_low_cycles", 32'(low_cnt), 32'd1);
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_coef", coef_o, 32'h08070605);
    step(1'b0, 8'h00, 1'b0);

    // asynchronous reset in the middle of a frame
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_coef", coef_o, 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_rdy", 32'(in_ready), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (src[i]) void'(src.pop_front());
    src = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    foreach (src[i]) step(1'b1, src[i], 1'b0);
    chk("rst_after_upd", 32'(coef_update), 32'h1);
    chk("rst_after_coef", coef_o, 32'h44332211);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if (gen.size() == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          gen.push_back(8'($urandom));
        end else begin
          gen.push_back(8'hA5);
          cs = '0;
          for (int k = 0; k < NB; k++) begin
            b = 8'($urandom);
            gen.push_back(b);
            cs ^= b;
          end
          if ($urandom_range(0, 4) == 0) cs ^= 8'($urandom_range(1, 255));
          gen.push_back(cs);
        end
      end
      v  = ($urandom_range(0, 9) < 8);
      ab = ($urandom_range(0, 49) == 0);
      b  = v ? gen[0] : 8'($urandom);
      in_valid = v; in_data = b; abort = ab;
      #1;
      chk("rnd_rdy", 32'(in_ready), 32'(m_rdy));
      acc = v && m_rdy && !ab;
      step(v, b, ab);
      if (acc) void'(gen.pop_front());
      chk("rnd_coef", coef_o, m_coef);
      chk("rnd_upd", 32'(coef_update), 32'(m_upd));
      chk("rnd_busy", 32'(busy), 32'(m_inframe));
      chk("rnd_err", 32'(err), 32'(m_err));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
